// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointers, per-domain fill levels and sticky error flags.
// Define ASYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle latency.
module async_fifo_gray #(
  parameter int DATA_W      = 66,
  parameter int ADDR_W      = 4,
  parameter int AFULL_TH    = 12,
  parameter int AEMPTY_TH   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_wclk,
  input  logic              i_rclk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_full,
  output logic              o_afull,
  output logic [ADDR_W:0]   o_wcount,
  output logic              o_overflow,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_aempty,
  output logic [ADDR_W:0]   o_rcount,
  output logic              o_underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_MASK  = {2'b11, {(ADDR_W-1){1'b0}}};
  localparam logic [ADDR_W:0] AFULL_LVL  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_LVL = (ADDR_W+1)'(AEMPTY_TH);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wbin, wgray, wbin_next, wgray_next, rgray_w, rbin_w, wcount_next;
  logic [SYNC_STAGES-1:0][ADDR_W:0] rgray_sync;
  logic push_ok;

  assign push_ok     = i_push && !o_full;
  assign wbin_next   = wbin + {{ADDR_W{1'b0}}, push_ok};
  assign wgray_next  = bin2gray(wbin_next);
  assign rgray_w     = rgray_sync[SYNC_STAGES-1];
  assign rbin_w      = gray2bin(rgray_w);
  assign wcount_next = wbin_next - rbin_w;

  logic [ADDR_W:0] rgray;

  always_ff @(posedge i_wclk) begin
    if (i_reset) begin
      wbin       <= '0;
      wgray      <= '0;
      rgray_sync <= '0;
      o_full     <= 1'b0;
      o_afull    <= 1'b0;
      o_wcount   <= '0;
      o_overflow <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      wgray      <= wgray_next;
      rgray_sync <= {rgray_sync[SYNC_STAGES-2:0], rgray};
      o_full     <= (wgray_next == (rgray_w ^ FULL_MASK));
      o_afull    <= (wcount_next >= AFULL_LVL);
      o_wcount   <= wcount_next;
      o_overflow <= o_overflow | (i_push & o_full);
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge i_wclk) begin
    if (push_ok) mem[wbin[ADDR_W-1:0]] <= i_wdata;
  end

  logic [SYNC_STAGES-1:0] rrst_sync;
  logic rrst;

  always_ff @(posedge i_rclk) begin
    rrst_sync <= {rrst_sync[SYNC_STAGES-2:0], i_reset};
  end
  assign rrst = rrst_sync[SYNC_STAGES-1];

  logic [ADDR_W:0] rbin, rbin_next, rgray_next, wgray_r, wbin_r, rcount_next;
  logic [SYNC_STAGES-1:0][ADDR_W:0] wgray_sync;
  logic rd_en, underflow_now;

  assign rbin_next  = rbin + {{ADDR_W{1'b0}}, rd_en};
  assign rgray_next = bin2gray(rbin_next);
  assign wgray_r    = wgray_sync[SYNC_STAGES-1];
  assign wbin_r     = gray2bin(wgray_r);

`ifdef ASYNC_FIFO_FWFT_EN
  // The output register holds the head word; memory is read whenever that slot is free or being consumed.
  logic head_valid, head_valid_next, core_empty;

  assign rd_en           = !core_empty && (!head_valid || i_pop);
  assign head_valid_next = rd_en || (head_valid && !i_pop);
  assign rcount_next     = wbin_r - rbin_next + {{ADDR_W{1'b0}}, head_valid_next};
  assign underflow_now   = i_pop && !head_valid;
  assign o_empty         = !head_valid;

  always_ff @(posedge i_rclk) begin
    if (rrst) begin
      core_empty <= 1'b1;
      head_valid <= 1'b0;
    end else begin
      core_empty <= (rgray_next == wgray_r);
      head_valid <= head_valid_next;
    end
  end
`else
  assign rd_en         = i_pop && !o_empty;
  assign rcount_next   = wbin_r - rbin_next;
  assign underflow_now = i_pop && o_empty;

  always_ff @(posedge i_rclk) begin
    if (rrst) o_empty <= 1'b1;
    else      o_empty <= (rgray_next == wgray_r);
  end
`endif

  always_ff @(posedge i_rclk) begin
    if (rrst) begin
      rbin        <= '0;
      rgray       <= '0;
      wgray_sync  <= '0;
      o_rcount    <= '0;
      o_aempty    <= 1'b1;
      o_underflow <= 1'b0;
      o_rdata     <= '0;
    end else begin
      rbin        <= rbin_next;
      rgray       <= rgray_next;
      wgray_sync  <= {wgray_sync[SYNC_STAGES-2:0], wgray};
      o_rcount    <= rcount_next;
      o_aempty    <= (rcount_next <= AEMPTY_LVL);
      o_underflow <= o_underflow | underflow_now;
      if (rd_en) o_rdata <= mem[rbin[ADDR_W-1:0]];
    end
  end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed self-checking bench for async_fifo_gray: fill/drain vector tables plus reset,
// latency and long streaming sequences. Follows ASYNC_FIFO_FWFT_EN when it is defined.
`timescale 1ns/100ps
module tb_async_fifo_gray;

  localparam int DATA_W      = 66;
  localparam int ADDR_W      = 4;
  localparam int DEPTH       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int N_STREAM    = 10000;
`ifdef ASYNC_FIFO_FWFT_EN
  localparam bit FWFT    = 1'b1;
  localparam int LAT_MAX = SYNC_STAGES + 2;
`else
  localparam bit FWFT    = 1'b0;
  localparam int LAT_MAX = SYNC_STAGES + 1;
`endif

  logic              wclk = 1'b0, rclk = 1'b0;
  logic              reset = 1'b1, push = 1'b0, pop = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic              full, afull, overflow, empty, aempty, underflow;
  logic [ADDR_W:0]   wcount, rcount;
  logic [DATA_W-1:0] rdata;

  int checks = 0;
  int errors = 0;

  always #3.2 wclk = ~wclk;
  always #5   rclk = ~rclk;

  async_fifo_gray #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(12), .AEMPTY_TH(2), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .i_wclk(wclk), .i_rclk(rclk), .i_reset(reset),
    .i_push(push), .i_wdata(wdata), .o_full(full), .o_afull(afull),
    .o_wcount(wcount), .o_overflow(overflow),
    .i_pop(pop), .o_rdata(rdata), .o_empty(empty), .o_aempty(aempty),
    .o_rcount(rcount), .o_underflow(underflow)
  );

  typedef struct {
    logic              push;
    logic [DATA_W-1:0] wdata;
    logic              full, afull, overflow;
    logic [ADDR_W:0]   wcount;
  } wvec_t;

  typedef struct {
    logic              pop;
    logic [DATA_W-1:0] rdata;
    logic              empty, aempty, underflow;
    logic [ADDR_W:0]   rcount;
  } rvec_t;

  wvec_t wvecs[17];
  rvec_t rvecs[17];

  task automatic check_output(input string name, input logic [DATA_W-1:0] actual,
                              input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_wclk(input int n);
    repeat (n) begin @(posedge wclk); #1; end
  endtask

  task automatic wait_rclk(input int n);
    repeat (n) begin @(posedge rclk); #1; end
  endtask

  function automatic logic [DATA_W-1:0] gen_word(input int n);
    logic [31:0] u;
    u = n;
    return {u, ~u, u[1:0]};
  endfunction

  task automatic apply_reset();
    @(posedge wclk); #1;
    reset = 1'b1;
    push  = 1'b0;
    wait_rclk(SYNC_STAGES + 4);
    @(posedge wclk); #1;
    reset = 1'b0;
    wait_rclk(SYNC_STAGES + 4);
  endtask

  task automatic apply_stimulus_w(input int i);
    push  = wvecs[i].push;
    wdata = wvecs[i].wdata;
    @(posedge wclk); #1;
    check_bit($sformatf("full[%0d]", i), full, wvecs[i].full);
    check_bit($sformatf("afull[%0d]", i), afull, wvecs[i].afull);
    check_bit($sformatf("overflow[%0d]", i), overflow, wvecs[i].overflow);
    check_output($sformatf("wcount[%0d]", i), DATA_W'(wcount), DATA_W'(wvecs[i].wcount));
  endtask

  task automatic apply_stimulus_r(input int i);
    pop = rvecs[i].pop;
    @(posedge rclk); #1;
    check_output($sformatf("rdata[%0d]", i), rdata, rvecs[i].rdata);
    check_bit($sformatf("empty[%0d]", i), empty, rvecs[i].empty);
    check_bit($sformatf("aempty[%0d]", i), aempty, rvecs[i].aempty);
    check_bit($sformatf("underflow[%0d]", i), underflow, rvecs[i].underflow);
    check_output($sformatf("rcount[%0d]", i), DATA_W'(rcount), DATA_W'(rvecs[i].rcount));
  endtask

  // Waits (bounded) for a word, then consumes it; in FWFT the head is sampled before the pop.
  task automatic read_one(input string name, output logic [DATA_W-1:0] data);
    int n = 0;
    @(posedge rclk); #1;
    while (empty && n < 20) begin @(posedge rclk); #1; n++; end
    check_bit({name, "_available"}, empty, 1'b0);
    if (FWFT) data = rdata;
    pop = 1'b1;
    @(posedge rclk); #1;
    pop = 1'b0;
    if (!FWFT) data = rdata;
  endtask

  initial begin
    logic [DATA_W-1:0] got;
    int wr_n, rd_n, both_cnt, lat;

    for (int i = 0; i < 17; i++) begin
      int n;
      n = (i < DEPTH) ? i + 1 : DEPTH;
      wvecs[i].push     = 1'b1;
      wvecs[i].wdata    = (i < DEPTH) ? DATA_W'(i) : DATA_W'(32'h99);
      wvecs[i].wcount   = (ADDR_W+1)'(n);
      wvecs[i].full     = (n == DEPTH);
      wvecs[i].afull    = (n >= 12);
      wvecs[i].overflow = (i == 16);
    end
    for (int k = 1; k <= 17; k++) begin
      int n;
      n = (k <= DEPTH) ? DEPTH - k : 0;
      rvecs[k-1].pop       = 1'b1;
      if (FWFT) rvecs[k-1].rdata = (k < DEPTH) ? DATA_W'(k) : DATA_W'(15);
      else      rvecs[k-1].rdata = (k <= DEPTH) ? DATA_W'(k - 1) : DATA_W'(15);
      rvecs[k-1].rcount    = (ADDR_W+1)'(n);
      rvecs[k-1].empty     = (n == 0);
      rvecs[k-1].aempty    = (n <= 2);
      rvecs[k-1].underflow = (k == 17);
    end

    apply_reset();
    check_bit("rst_empty", empty, 1'b1);
    check_bit("rst_aempty", aempty, 1'b1);
    check_bit("rst_full", full, 1'b0);
    check_bit("rst_afull", afull, 1'b0);
    check_bit("rst_overflow", overflow, 1'b0);
    check_bit("rst_underflow", underflow, 1'b0);
    check_output("rst_wcount", DATA_W'(wcount), '0);
    check_output("rst_rcount", DATA_W'(rcount), '0);
    check_output("rst_rdata", rdata, '0);

    $display("[TB] fill 16 words plus one overflow push");
    @(posedge wclk); #1;
    for (int i = 0; i < 17; i++) apply_stimulus_w(i);
    push = 1'b0;

    wait_rclk(SYNC_STAGES + 3);
    check_bit("pre_drain_empty", empty, 1'b0);
    check_bit("pre_drain_aempty", aempty, 1'b0);
    check_output("pre_drain_rcount", DATA_W'(rcount), DATA_W'(DEPTH));
    check_output("pre_drain_rdata", rdata, '0);

    $display("[TB] drain 16 words plus one underflow pop");
    for (int i = 0; i < 17; i++) apply_stimulus_r(i);
    pop = 1'b0;

    wait_wclk(SYNC_STAGES + 3);
    check_bit("post_drain_full", full, 1'b0);
    check_bit("post_drain_afull", afull, 1'b0);
    check_bit("overflow_sticky", overflow, 1'b1);
    check_output("post_drain_wcount", DATA_W'(wcount), '0);

    $display("[TB] reset with 7 words stored");
    for (int i = 0; i < 7; i++) begin
      push  = 1'b1;
      wdata = DATA_W'(32'h70 + i);
      @(posedge wclk); #1;
    end
    push = 1'b0;
    wait_wclk(2);
    check_output("seven_wcount", DATA_W'(wcount), DATA_W'(7));
    apply_reset();
    check_bit("rst2_empty", empty, 1'b1);
    check_bit("rst2_full", full, 1'b0);
    check_bit("rst2_overflow", overflow, 1'b0);
    check_bit("rst2_underflow", underflow, 1'b0);
    check_output("rst2_wcount", DATA_W'(wcount), '0);
    check_output("rst2_rcount", DATA_W'(rcount), '0);

    @(posedge wclk); #1;
    push  = 1'b1;
    wdata = DATA_W'(32'hA5);
    @(posedge wclk); #1;
    push  = 1'b0;
    read_one("a5", got);
    check_output("a5_data", got, DATA_W'(32'hA5));

    $display("[TB] streaming %0d words with random stalls", N_STREAM);
    wr_n = 0;
    rd_n = 0;
    both_cnt = 0;
    fork
      begin
        int cyc = 0;
        @(posedge wclk); #1;
        while (wr_n < N_STREAM && cyc < 60000) begin
          push  = !full && ($urandom_range(0, 3) != 0);
          wdata = gen_word(wr_n);
          @(posedge wclk); #1;
          cyc++;
          if (push) wr_n++;
        end
        push = 1'b0;
      end
      begin
        int cyc = 0;
        logic acc;
        @(posedge rclk); #1;
        while (rd_n < N_STREAM && cyc < 60000) begin
          if (full && empty) both_cnt++;
          acc = !empty && ($urandom_range(0, 3) != 0);
          if (FWFT && acc) begin
            check_output("stream_data", rdata, gen_word(rd_n));
            rd_n++;
          end
          pop = acc;
          @(posedge rclk); #1;
          cyc++;
          if (!FWFT && acc) begin
            check_output("stream_data", rdata, gen_word(rd_n));
            rd_n++;
          end
        end
        pop = 1'b0;
      end
    join
    check_int("stream_words_read", rd_n, N_STREAM);
    check_int("full_and_empty_samples", both_cnt, 0);
    check_bit("stream_overflow", overflow, 1'b0);
    check_bit("stream_underflow", underflow, 1'b0);

    $display("[TB] single push empty-deassert latency");
    wait_rclk(SYNC_STAGES + 4);
    check_bit("latency_start_empty", empty, 1'b1);
    @(posedge wclk); #1;
    push  = 1'b1;
    wdata = DATA_W'(32'h3C);
    lat   = 0;
    fork
      begin
        @(posedge wclk); #1;
        push = 1'b0;
      end
      begin
        @(posedge wclk);
        while (lat < 8) begin
          @(posedge rclk);
          lat++;
          #1;
          if (!empty) break;
        end
      end
    join
    checks++;
    if (empty || lat > LAT_MAX) begin
      errors++;
      $display("[TB] FAIL empty_latency: got %0d edges (empty=%b), required <= %0d", lat, empty, LAT_MAX);
    end
    if (FWFT) check_output("fwft_head_before_pop", rdata, DATA_W'(32'h3C));
    read_one("latency_word", got);
    check_output("latency_word_data", got, DATA_W'(32'h3C));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
